// File: rtl/trecere_cerere_pkg.sv
// ----------------------------------------------------------------------------
// trecere_pkg : shared types and helpers for the trecere_cerere
//               pedestrian-crossing controller.
//   stare_t    : FSM state encoding. NOAPTE is present only when
//                TRECERE_NOAPTE_EN is defined.
//   lampi_t    : packed lamp vector {p_rosu, p_verde, m_rosu, m_galben, m_verde}.
//   max_durata : largest of the five phase durations, used to size the timer.
// Optional feature macro: TRECERE_NOAPTE_EN (night / blinking-yellow mode).
// ----------------------------------------------------------------------------
package trecere_pkg;

   typedef enum logic [2:0] {
      M_VERDE   = 3'd0,
      M_GALBEN  = 3'd1,
      TOT_ROSU1 = 3'd2,
      P_VERDE   = 3'd3,
      P_CLIPIRE = 3'd4,
      TOT_ROSU2 = 3'd5
`ifdef TRECERE_NOAPTE_EN
      , NOAPTE  = 3'd6
`endif
   } stare_t;

   typedef struct packed {
      logic p_rosu;
      logic p_verde;
      logic m_rosu;
      logic m_galben;
      logic m_verde;
   } lampi_t;

   // Lamp state shown while reset is asserted and on entry to car green.
   localparam lampi_t LAMPI_RESET = 5'b10001;

   function automatic int max_durata(input int a, input int b, input int c,
                                     input int d, input int e);
      int m;
      m = a;
      if (b > m) m = b; else m = m;
      if (c > m) m = c; else m = m;
      if (d > m) m = d; else m = m;
      if (e > m) m = e; else m = m;
      return m;
   endfunction

endpackage

// File: rtl/trecere_cerere_if.sv
// ----------------------------------------------------------------------------
// trecere_cerere_if : pedestrian request input and lamp outputs of the
//                     crossing controller, grouped as one bundle.
//   master : environment side (drives buton_p / noapte, reads lamps).
//   slave  : controller side (reads buton_p / noapte, drives lamps).
//   buton_p       pedestrian request button, level
//   noapte        night-mode request (only with TRECERE_NOAPTE_EN)
//   p_rosu/p_verde               pedestrian lamps
//   m_rosu/m_galben/m_verde      car lamps
//   cerere_activa                request-pending ("wait") lamp
// ----------------------------------------------------------------------------
interface trecere_cerere_if;

   logic buton_p;
`ifdef TRECERE_NOAPTE_EN
   logic noapte;
`endif
   logic p_rosu;
   logic p_verde;
   logic m_rosu;
   logic m_galben;
   logic m_verde;
   logic cerere_activa;

   modport master (
      output buton_p,
`ifdef TRECERE_NOAPTE_EN
      output noapte,
`endif
      input  p_rosu,
      input  p_verde,
      input  m_rosu,
      input  m_galben,
      input  m_verde,
      input  cerere_activa
   );

   modport slave (
      input  buton_p,
`ifdef TRECERE_NOAPTE_EN
      input  noapte,
`endif
      output p_rosu,
      output p_verde,
      output m_rosu,
      output m_galben,
      output m_verde,
      output cerere_activa
   );

endinterface

// File: rtl/trecere_cerere_temporizator.sv
// ----------------------------------------------------------------------------
// temporizator : per-state timer of the crossing controller.
//   clk, rst_n : clock, asynchronous active-low reset (count -> 0)
//   clr        : synchronous clear, has priority over counting
//   en         : count enable
//   satur      : 1 = stop at all-ones, 0 = wrap around
//   cnt_q      : current count
//   cnt_d      : count that will be loaded at the next edge (lets the
//                parent register outputs decoded from the next timer value)
// ----------------------------------------------------------------------------
module temporizator #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic             satur,
   output logic [CNT_W-1:0] cnt_q,
   output logic [CNT_W-1:0] cnt_d
);

   localparam logic [CNT_W-1:0] UNU = {{(CNT_W-1){1'b0}}, 1'b1};

   // Next count: clear, hold at saturation, or increment.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         if (satur && (&cnt_q)) begin
            cnt_d = cnt_q;
         end else begin
            cnt_d = cnt_q + UNU;
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/trecere_cerere.sv
// ----------------------------------------------------------------------------
// trecere_cerere : request-driven pedestrian-crossing controller.
//   Car green is held until a pedestrian request is pending and the minimum
//   car-green time has elapsed; then car yellow, all-red guard, pedestrian
//   green, blinking pedestrian green, all-red guard, back to car green.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous reset, active low
//   bus    : trecere_cerere_if.slave (buton_p in, lamps + cerere_activa out)
// Optional feature macro: TRECERE_NOAPTE_EN adds bus.noapte and a NOAPTE
//   state (blinking car yellow, all other lamps dark), entered only from
//   car green.
// All lamps are flops loaded from the decode of the next state and next
// timer value, so they always match the current state/timer and never
// depend combinationally on inputs.
// ----------------------------------------------------------------------------
module trecere_cerere
   import trecere_pkg::*;
#(
   parameter int CNT_W        = 8,
   parameter int T_MVERDE_MIN = 30,
   parameter int T_GALBEN     = 5,
   parameter int T_GARDA      = 2,
   parameter int T_PVERDE     = 20,
   parameter int T_PCLIPIRE   = 6,
   parameter int CLIP_LOG2    = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   trecere_cerere_if.slave        bus
);

   localparam int MAX_DUR = max_durata(T_MVERDE_MIN, T_GALBEN, T_GARDA,
                                       T_PVERDE, T_PCLIPIRE);

   if (T_MVERDE_MIN < 1 || T_GALBEN < 1 || T_GARDA < 1 ||
       T_PVERDE < 1 || T_PCLIPIRE < 1) begin : g_err_durata
      $error("trecere_cerere: every phase duration must be at least 1");
   end
   if (CNT_W < 1 || CNT_W > 30 || ((MAX_DUR - 1) >> CNT_W) != 0) begin : g_err_latime
      $error("trecere_cerere: CNT_W cannot hold the longest duration - 1");
   end
   if (CLIP_LOG2 < 0 || CLIP_LOG2 >= CNT_W) begin : g_err_clip
      $error("trecere_cerere: CLIP_LOG2 must index a timer bit");
   end

   localparam logic [CNT_W-1:0] LIM_MVERDE  = CNT_W'(T_MVERDE_MIN - 1);
   localparam logic [CNT_W-1:0] LIM_GALBEN  = CNT_W'(T_GALBEN - 1);
   localparam logic [CNT_W-1:0] LIM_GARDA   = CNT_W'(T_GARDA - 1);
   localparam logic [CNT_W-1:0] LIM_PVERDE  = CNT_W'(T_PVERDE - 1);
   localparam logic [CNT_W-1:0] LIM_PCLIP   = CNT_W'(T_PCLIPIRE - 1);

   stare_t           stare_q, stare_d;
   logic             cerere_q, cerere_d;
   lampi_t           lampi_q, lampi_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic             schimbare_s;
   logic             noapte_s;
   logic             in_noapte_s;
   logic             spre_noapte_s;
   logic             intrare_pverde_s;
   logic             cerere_permisa_s;

`ifdef TRECERE_NOAPTE_EN
   assign noapte_s      = bus.noapte;
   assign in_noapte_s   = (stare_q == NOAPTE);
   assign spre_noapte_s = (stare_d == NOAPTE);
`else
   assign noapte_s      = 1'b0;
   assign in_noapte_s   = 1'b0;
   assign spre_noapte_s = 1'b0;
`endif

   // Lamp pattern for a given state and timer value.
   function automatic lampi_t decodare(input stare_t s, input logic [CNT_W-1:0] t);
      lampi_t l;
      l = '0;
      case (s)
         M_VERDE:   begin l.m_verde  = 1'b1; l.p_rosu = 1'b1; end
         M_GALBEN:  begin l.m_galben = 1'b1; l.p_rosu = 1'b1; end
         TOT_ROSU1: begin l.m_rosu   = 1'b1; l.p_rosu = 1'b1; end
         TOT_ROSU2: begin l.m_rosu   = 1'b1; l.p_rosu = 1'b1; end
         P_VERDE:   begin l.m_rosu   = 1'b1; l.p_verde = 1'b1; end
         // First half-period lit: timer bit is 0 right after entry.
         P_CLIPIRE: begin l.m_rosu   = 1'b1; l.p_verde = ~t[CLIP_LOG2]; end
`ifdef TRECERE_NOAPTE_EN
         // Blinking yellow starts dark; pedestrian lamps off too.
         NOAPTE:    begin l.m_galben = t[CLIP_LOG2]; end
`endif
         default:   begin l = LAMPI_RESET; end
      endcase
      return l;
   endfunction

   // Next-state selection from the current state, timer and request.
   always_comb begin
      stare_d = stare_q;
      case (stare_q)
         M_VERDE: begin
`ifdef TRECERE_NOAPTE_EN
            // Night mode wins over a pending request and ignores the minimum.
            if (noapte_s) begin
               stare_d = NOAPTE;
            end else if ((timer_q >= LIM_MVERDE) && (cerere_q || bus.buton_p)) begin
               stare_d = M_GALBEN;
            end else begin
               stare_d = M_VERDE;
            end
`else
            if ((timer_q >= LIM_MVERDE) && (cerere_q || bus.buton_p)) begin
               stare_d = M_GALBEN;
            end else begin
               stare_d = M_VERDE;
            end
`endif
         end
         M_GALBEN: begin
            if (timer_q == LIM_GALBEN) stare_d = TOT_ROSU1;
            else                       stare_d = M_GALBEN;
         end
         TOT_ROSU1: begin
            if (timer_q == LIM_GARDA)  stare_d = P_VERDE;
            else                       stare_d = TOT_ROSU1;
         end
         P_VERDE: begin
            if (timer_q == LIM_PVERDE) stare_d = P_CLIPIRE;
            else                       stare_d = P_VERDE;
         end
         P_CLIPIRE: begin
            if (timer_q == LIM_PCLIP)  stare_d = TOT_ROSU2;
            else                       stare_d = P_CLIPIRE;
         end
         TOT_ROSU2: begin
            if (timer_q == LIM_GARDA)  stare_d = M_VERDE;
            else                       stare_d = TOT_ROSU2;
         end
`ifdef TRECERE_NOAPTE_EN
         NOAPTE: begin
            if (noapte_s) stare_d = NOAPTE;
            else          stare_d = TOT_ROSU2;
         end
`endif
         default: begin
            stare_d = M_VERDE;
         end
      endcase
   end

   assign schimbare_s      = (stare_d != stare_q);
   assign intrare_pverde_s = (stare_d == P_VERDE) && (stare_q != P_VERDE);
   // Presses during pedestrian service (and in night mode) are ignored.
   assign cerere_permisa_s = (stare_q != P_VERDE) && (stare_q != P_CLIPIRE) && !in_noapte_s;

   // Request latch: clear on serving (or night) has priority over a new press.
   always_comb begin
      cerere_d = cerere_q;
      if (intrare_pverde_s || spre_noapte_s) begin
         cerere_d = 1'b0;
      end else if (bus.buton_p && cerere_permisa_s) begin
         cerere_d = 1'b1;
      end else begin
         cerere_d = cerere_q;
      end
   end

   // Lamps are decoded from the values the state and timer are about to take.
   always_comb begin
      lampi_d = decodare(stare_d, timer_d);
   end

   // Car green saturates while waiting; night mode lets the timer wrap.
   temporizator #(
      .CNT_W (CNT_W)
   ) u_temporizator (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (schimbare_s),
      .en    (1'b1),
      .satur (stare_q == M_VERDE),
      .cnt_q (timer_q),
      .cnt_d (timer_d)
   );

   // State, request latch and registered lamps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stare_q  <= M_VERDE;
         cerere_q <= 1'b0;
         lampi_q  <= LAMPI_RESET;
      end else begin
         stare_q  <= stare_d;
         cerere_q <= cerere_d;
         lampi_q  <= lampi_d;
      end
   end

   assign bus.p_rosu        = lampi_q.p_rosu;
   assign bus.p_verde       = lampi_q.p_verde;
   assign bus.m_rosu        = lampi_q.m_rosu;
   assign bus.m_galben      = lampi_q.m_galben;
   assign bus.m_verde       = lampi_q.m_verde;
   assign bus.cerere_activa = cerere_q;

endmodule

// File: tb/tb_trecere_cerere.sv
// ----------------------------------------------------------------------------
// tb_trecere_cerere : self-checking bench for trecere_cerere with
//   T_MVERDE_MIN=4, T_GALBEN=2, T_GARDA=1, T_PVERDE=3, T_PCLIPIRE=4, CLIP_LOG2=0.
// A phase-table reference model tracks the expected lamps and request flag.
// Night-mode checks are compiled only with TRECERE_NOAPTE_EN.
// ----------------------------------------------------------------------------
module tb_trecere_cerere;

   localparam int CLIP = 0;
   // Phase durations, indexed 0=car green (minimum) ... 5=second guard.
   localparam int DUR [6] = '{4, 2, 1, 3, 4, 1};

   // Lamp vectors {p_rosu, p_verde, m_rosu, m_galben, m_verde}.
   localparam logic [4:0] MV = 5'b10001;
   localparam logic [4:0] GA = 5'b10010;
   localparam logic [4:0] AR = 5'b10100;
   localparam logic [4:0] PV = 5'b01100;
   localparam logic [4:0] PO = 5'b00100;

   logic clk;
   logic rst_n;
   logic btn;
   logic nt;
   int   total;
   int   bad;

   trecere_cerere_if bus ();

   assign bus.buton_p = btn;
`ifdef TRECERE_NOAPTE_EN
   assign bus.noapte = nt;
`endif

   trecere_cerere #(
      .CNT_W        (8),
      .T_MVERDE_MIN (4),
      .T_GALBEN     (2),
      .T_GARDA      (1),
      .T_PVERDE     (3),
      .T_PCLIPIRE   (4),
      .CLIP_LOG2    (CLIP)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [4:0] lmp;
   assign lmp = {bus.p_rosu, bus.p_verde, bus.m_rosu, bus.m_galben, bus.m_verde};

   // ---------------- reference model ----------------
   // ph: 0..5 normal phases in order, 6 = night. el: cycles spent in phase.
   typedef struct { int ph; int el; bit req; } mdl_t;
   mdl_t mdl;

   function automatic mdl_t urm(mdl_t c, bit b, bit n);
      mdl_t r;
      int   nx;
      r  = c;
      nx = c.ph;
      if (c.ph == 6)      nx = n ? 6 : 5;
      else if (c.ph == 0) begin
         if (n) nx = 6;
         else if (c.el >= DUR[0] - 1 && (c.req || b)) nx = 1;
      end
      else if (c.el == DUR[c.ph] - 1) nx = (c.ph + 1) % 6;
      if (b && c.ph != 3 && c.ph != 4 && c.ph != 6) r.req = 1'b1;
      if ((nx == 3 && c.ph != 3) || nx == 6) r.req = 1'b0;
      if (nx != c.ph)    r.el = 0;
      else if (c.ph == 0) r.el = (c.el < 255) ? c.el + 1 : 255;
      else               r.el = (c.el + 1) % 256;
      r.ph = nx;
      return r;
   endfunction

   function automatic logic [4:0] lampi_ref(mdl_t m);
      case (m.ph)
         0:       return MV;
         1:       return GA;
         2, 5:    return AR;
         3:       return PV;
         4:       return (((m.el >> CLIP) & 1) == 0) ? PV : PO;
         6:       return (((m.el >> CLIP) & 1) != 0) ? 5'b00010 : 5'b00000;
         default: return 5'b11111;
      endcase
   endfunction

`ifdef TRECERE_NOAPTE_EN
   wire nt_m = nt;
`else
   wire nt_m = 1'b0;
`endif

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) mdl <= '{0, 0, 1'b0};
      else        mdl <= urm(mdl, btn, nt_m);
   end

   // ---------------- helpers ----------------
   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Advance one cycle and compare against the model.
   task automatic nxt();
      @(negedge clk);
      chk("model_lamps", {3'b000, lmp}, {3'b000, lampi_ref(mdl)});
      chk("model_req", {7'd0, bus.cerere_activa}, {7'd0, mdl.req});
      if (mdl.ph != 6) begin
         chk("one_car_lamp", 8'($countones(lmp[2:0])), 8'd1);
      end
      chk("greens_excl", {7'd0, lmp[3] & lmp[0]}, 8'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; btn = 1'b0; nt = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_lamps", {3'b000, lmp}, {3'b000, MV});
      chk("rst_req", {7'd0, bus.cerere_activa}, 8'd0);
      rst_n = 1'b1;
   endtask

   typedef struct { bit btn; logic [4:0] lmp; bit req; } vec_t;
   vec_t tbl[$];

   task automatic add(input int n, input bit b, input logic [4:0] l, input bit r);
      vec_t v;
      v.btn = b; v.lmp = l; v.req = r;
      for (int i = 0; i < n; i++) tbl.push_back(v);
   endtask

   int hold;

   initial begin
      total = 0; bad = 0; rst_n = 1'b0; btn = 1'b0; nt = 1'b0; hold = 0;

      // Idle: car green forever, no request.
      do_reset();
      for (int k = 0; k < 50; k++) begin
         chk("idle_lamps", {3'b000, lmp}, {3'b000, MV});
         chk("idle_req", {7'd0, bus.cerere_activa}, 8'd0);
         btn = 1'b0;
         nxt();
      end

      // One pulse at cycle 10: a full pedestrian cycle, table driven.
      add(10, 1'b0, MV, 1'b0);
      add(1,  1'b1, MV, 1'b0);
      add(2,  1'b0, GA, 1'b1);
      add(1,  1'b0, AR, 1'b1);
      add(3,  1'b0, PV, 1'b0);
      add(1,  1'b0, PV, 1'b0);
      add(1,  1'b0, PO, 1'b0);
      add(1,  1'b0, PV, 1'b0);
      add(1,  1'b0, PO, 1'b0);
      add(1,  1'b0, AR, 1'b0);
      add(5,  1'b0, MV, 1'b0);
      do_reset();
      foreach (tbl[k]) begin
         chk("tbl_lamps", {3'b000, lmp}, {3'b000, tbl[k].lmp});
         chk("tbl_req", {7'd0, bus.cerere_activa}, {7'd0, tbl[k].req});
         btn = tbl[k].btn;
         nxt();
      end

      // Press before the minimum: latched, served at cycle 4.
      do_reset();
      btn = 1'b0; nxt();
      btn = 1'b1; nxt();
      btn = 1'b0;
      chk("early_req_c2", {7'd0, bus.cerere_activa}, 8'd1);
      chk("early_lmp_c2", {3'b000, lmp}, {3'b000, MV});
      nxt();
      chk("early_lmp_c3", {3'b000, lmp}, {3'b000, MV});
      nxt();
      chk("early_lmp_c4", {3'b000, lmp}, {3'b000, GA});

      // Press during pedestrian green is ignored.
      do_reset();
      for (int k = 0; k < 60; k++) begin
         if (k == 11) begin
            chk("pv_ign_lmp", {3'b000, lmp}, {3'b000, PV});
            chk("pv_ign_req", {7'd0, bus.cerere_activa}, 8'd0);
         end
         if (k >= 17) begin
            chk("pv_ign_hold_lmp", {3'b000, lmp}, {3'b000, MV});
            chk("pv_ign_hold_req", {7'd0, bus.cerere_activa}, 8'd0);
         end
         btn = (k == 5 || k == 10);
         nxt();
      end

      // Asynchronous reset mid blinking green, then a held button.
      do_reset();
      for (int k = 0; k < 13; k++) begin
         btn = (k == 5);
         nxt();
      end
      chk("pc_before_rst", {3'b000, lmp}, {3'b000, PO});
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_lmp", {3'b000, lmp}, {3'b000, MV});
      chk("async_rst_req", {7'd0, bus.cerere_activa}, 8'd0);
      @(negedge clk);
      rst_n = 1'b1;
      btn = 1'b1;
      for (int k = 0; k < 20; k++) begin
         logic [4:0] e;
         bit         er;
         e  = (k < 4 || (k >= 15 && k < 19)) ? MV :
              (k < 6 || k == 19)              ? GA :
              (k == 6 || k == 14)             ? AR :
              (k < 10)                        ? PV :
              ((k % 2) == 0)                  ? PV : PO;
         er = (k >= 1 && k <= 6) || k >= 15;
         chk("held_lmp", {3'b000, lmp}, {3'b000, e});
         chk("held_req", {7'd0, bus.cerere_activa}, {7'd0, er});
         nxt();
      end
      btn = 1'b0;

`ifdef TRECERE_NOAPTE_EN
      // Night mode: blinking yellow, presses ignored, guard then car green.
      do_reset();
      for (int k = 0; k < 12; k++) begin
         if (k >= 3 && k <= 6) begin
            chk("night_lmp", {3'b000, lmp}, {3'b000, ((k % 2) == 0) ? 5'b00010 : 5'b00000});
            chk("night_req", {7'd0, bus.cerere_activa}, 8'd0);
         end
         if (k == 7) chk("night_guard", {3'b000, lmp}, {3'b000, AR});
         if (k >= 8) begin
            chk("night_back", {3'b000, lmp}, {3'b000, MV});
            chk("night_back_req", {7'd0, bus.cerere_activa}, 8'd0);
         end
         nt  = (k >= 2 && k < 6);
         btn = (k == 4);
         nxt();
      end
      nt = 1'b0; btn = 1'b0;
`endif

      // Randomised run against the model, with rare asynchronous resets.
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         if (hold == 0 && $urandom_range(0, 11) == 0) hold = $urandom_range(1, 6);
         btn = (hold > 0);
         if (hold > 0) hold = hold - 1;
`ifdef TRECERE_NOAPTE_EN
         if ($urandom_range(0, 60) == 0) nt = ~nt;
`endif
         if ($urandom_range(0, 299) == 0) begin
            #3 rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
         end
         nxt();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
